// File: rtl/tick_sum_pkg.sv
// Shared types, constants and width helper for the tick_sum receiver.
package tick_sum_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StAccum = 2'd1;
   localparam state_t StEmit  = 2'd2;

   localparam int unsigned FRAME_CNT_W = 16;

   // One guard bit above the worst-case COUNT * (2^WIDTH - 1) sum.
   function automatic int unsigned sum_width(input int unsigned width, input int unsigned count);
      return width + $clog2(count) + 1;
   endfunction

endpackage

// File: rtl/tick_sum_acc.sv
// Frame accumulator and sample index with clear/load/add controls.
module tick_sum_acc
   import tick_sum_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned COUNT = 2,
   localparam int unsigned SUM_WIDTH = sum_width(WIDTH, COUNT),
   localparam int unsigned IDX_W = $clog2(COUNT + 1)
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 add,
   input  logic [WIDTH-1:0]     data,
   output logic [IDX_W-1:0]     idx,
   output logic [SUM_WIDTH-1:0] sum_next
);

   logic [SUM_WIDTH-1:0] acc_q;
   logic [IDX_W-1:0]     idx_q;
   logic [SUM_WIDTH-1:0] data_ext;

   assign data_ext = {{(SUM_WIDTH - WIDTH){1'b0}}, data};
   // Value the accumulator takes on this edge; the top registers it as the frame sum.
   assign sum_next = load ? data_ext : acc_q + data_ext;
   assign idx      = idx_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         idx_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
         idx_q <= '0;
      end else if (load) begin
         acc_q <= sum_next;
         idx_q <= IDX_W'(1);
      end else if (add) begin
         acc_q <= sum_next;
         idx_q <= idx_q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/tick_sum_receiver.sv
// Groups COUNT samples into frames and emits one registered sum per frame.
// Optional clamp of the sum to 2^WIDTH-1 when TICK_SUM_SATURATE_EN is defined.
module tick_sum_receiver
   import tick_sum_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned COUNT = 2,
   localparam int unsigned SUM_WIDTH = sum_width(WIDTH, COUNT)
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [SUM_WIDTH-1:0]   out_sum,
   output logic                   out_sat,
   input  logic                   out_ready,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned IDX_W = $clog2(COUNT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

   state_t                 state_q, state_d;
   logic                   alive_q;
   logic                   out_valid_q, out_valid_d;
   logic [SUM_WIDTH-1:0]   out_sum_q, out_sum_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   acc_clear, acc_load, acc_add, emit_load, accept;
   logic [IDX_W-1:0]       idx;
   logic [SUM_WIDTH-1:0]   sum_next, emit_sum;

   tick_sum_acc #(
      .WIDTH (WIDTH),
      .COUNT (COUNT)
   ) u_acc (
      .clock    (clock),
      .rst_n    (rst_n),
      .clear    (acc_clear),
      .load     (acc_load),
      .add      (acc_add),
      .data     (in_data),
      .idx      (idx),
      .sum_next (sum_next)
   );

   // alive_q keeps in_ready low until the first edge after reset release.
   assign in_ready = alive_q && (state_q != StEmit);
   assign accept   = in_valid && in_ready;

`ifdef TICK_SUM_SATURATE_EN
   localparam logic [SUM_WIDTH-1:0] SAT_MAX = {{(SUM_WIDTH - WIDTH){1'b0}}, {WIDTH{1'b1}}};
   logic emit_sat;
   logic out_sat_q;

   assign emit_sat = (sum_next > SAT_MAX);
   assign emit_sum = emit_sat ? SAT_MAX : sum_next;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_sat_q <= 1'b0;
      end else if (flush || (state_q == StEmit && out_ready)) begin
         out_sat_q <= 1'b0;
      end else if (emit_load) begin
         out_sat_q <= emit_sat;
      end
   end

   assign out_sat = out_sat_q;
`else
   assign emit_sum = sum_next;
   assign out_sat  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      frame_cnt_d = frame_cnt_q;
      acc_clear   = 1'b0;
      acc_load    = 1'b0;
      acc_add     = 1'b0;
      emit_load   = 1'b0;
      if (flush) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
         acc_clear   = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  acc_load = 1'b1;
                  if (COUNT == 1) emit_load = 1'b1;
                  else            state_d   = StAccum;
               end
            end
            StAccum: begin
               if (accept) begin
                  acc_add = 1'b1;
                  if (idx == LAST_IDX) emit_load = 1'b1;
               end
            end
            StEmit: begin
               if (out_ready) begin
                  state_d     = StIdle;
                  out_valid_d = 1'b0;
                  acc_clear   = 1'b1;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
            default: state_d = StIdle;
         endcase
         if (emit_load) begin
            state_d     = StEmit;
            out_valid_d = 1'b1;
            out_sum_d   = emit_sum;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         alive_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         alive_q     <= 1'b1;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tick_sum_receiver.sv
// Directed plus randomized bench for tick_sum_receiver (WIDTH=8, COUNT=2).
module tb_tick_sum_receiver;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [9:0]  out_sum;
   logic        out_sat;
   logic        out_ready = 1'b0;
   logic [15:0] frame_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_cnt = '0;

   tick_sum_receiver #(
      .WIDTH (8),
      .COUNT (2)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_sat   (out_sat),
      .out_ready (out_ready),
      .frame_cnt (frame_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a frame's result is the plain sum of its samples, optionally clamped.
   function automatic logic [10:0] model(input int unsigned s);
`ifdef TICK_SUM_SATURATE_EN
      if (s > 255) return {1'b1, 10'd255};
`endif
      return {1'b0, 10'(s)};
   endfunction

   task automatic push(input logic [7:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   // Called right after the last accept: out_valid must already be up.
   task automatic take(input string tag, input logic [9:0] esum, input logic esat);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(out_sum), 32'(esum));
      check({tag, "_sat"}, 32'(out_sat), 32'(esat));
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      exp_cnt++;
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
   endtask

   task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b);
      logic [10:0] r;
      push(a);
      push(b);
      r = model(int'(a) + int'(b));
      take(tag, r[9:0], r[10]);
   endtask

   initial begin
      logic [10:0] r;
      logic [7:0]  a, b;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_sat", 32'(out_sat), 32'd0);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clock); #1;
      check("rel_ready", 32'(in_ready), 32'd1);

      // First frame with out_ready held high
      out_ready = 1'b1;
      push(8'h00);
      check("f1_ready_low", 32'(out_valid), 32'd0);
      push(8'h01);
      take("f1", 10'd1, 1'b0);

      // Backpressure with a third sample waiting
      push(8'h10);
      push(8'h20);
      in_valid = 1'b1;
      in_data  = 8'h40;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_sum", 32'(out_sum), 32'h30);
         check("bp_ready", 32'(in_ready), 32'd0);
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      exp_cnt++;
      check("bp_drop", 32'(out_valid), 32'd0);
      check("bp_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("bp_ready_back", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      push(8'h01);
      take("bp_next", 10'h41, 1'b0);

      // Overflow boundary
      frame("ovf", 8'hFF, 8'hFF);

      // Flush mid-frame; the sample in the flush cycle is discarded
      push(8'h05);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h07;
      @(posedge clock); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_cnt", 32'(frame_cnt), 32'(exp_cnt));
      push(8'h01);
      push(8'h02);
      take("fl", 10'h03, 1'b0);

      // Flush while emitting drops the pending sum uncounted
      push(8'h09);
      push(8'h09);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("fle_valid", 32'(out_valid), 32'd0);
      check("fle_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("fle_ready", 32'(in_ready), 32'd1);

      // Randomized frames with random downstream stalls
      for (int k = 0; k < 30; k++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         push(a);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
         end
         push(b);
         r = model(int'(a) + int'(b));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
         end
         take("rnd", r[9:0], r[10]);
      end

      // Asynchronous reset between edges while emitting
      push(8'h11);
      push(8'h22);
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      check("ar_valid", 32'(out_valid), 32'd0);
      check("ar_cnt", 32'(frame_cnt), 32'd0);
      check("ar_sum", 32'(out_sum), 32'd0);
      @(posedge clock); #1;
      rst_n = 1'b1;
      @(posedge clock); #1;
      check("ar_ready", 32'(in_ready), 32'd1);
      frame("ar_next", 8'h33, 8'h44);

      // Frame counter wrap, starting just below the top
      force dut.frame_cnt_q = 16'hFFFD;
      #1;
      release dut.frame_cnt_q;
      exp_cnt = 16'hFFFD;
      for (int k = 0; k < 3; k++) frame("wrap", 8'h00, 8'h00);
      check("wrap_zero", 32'(frame_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
